ifetch_prefetch_buf: RTL

IFETCH_PREFETCH_BUF -- requirements
Module: ifetch_prefetch_buf

---
 rtl/ifetch_prefetch_buf.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ifetch_prefetch_buf.sv
// ifetch_prefetch_buf
// Instruction prefetch buffer between a core fetch port and a single-outstanding
// instruction memory read port. Sequential words are prefetched into a small
// FIFO of {addr, instr} pairs. The core is served with zero latency from the
// FIFO head or directly from a completing read (bypass). A non-matching
// request redirects the stream. A read still outstanding on redirect or flush
// is drained and its data dropped.
//
// Ports
//   clk_i        in   1   clock, all state updates on rising edge
//   rst_i        in   1   synchronous active-high reset
//   core_req_i   in   1   core fetch request
//   core_addr_i  in   AW  core fetch PC (word aligned)
//   core_ready_o out  1   instruction for core_addr_i valid this cycle
//   core_data_o  out  DW  instruction, 0 when core_ready_o is low
//   flush_i      in   1   discard all prefetched data
//   mem_req_o    out  1   memory read request
//   mem_addr_o   out  AW  memory read address, 0 while no request
//   mem_ready_i  in   1   read completes this cycle
//   mem_data_i   in   DW  read data, valid with mem_ready_i
module ifetch_prefetch_buf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          core_req_i,
    input  logic [AW-1:0] core_addr_i,
    output logic          core_ready_o,
    output logic [DW-1:0] core_data_o,
    input  logic          flush_i,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_ready_i,
    input  logic [DW-1:0] mem_data_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   fetch_addr_r;
    logic [AW-1:0]   drain_addr_r;
    logic            redirect_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [AW-1:0]   fifo_addr_r [DEPTH];
    logic [DW-1:0]   fifo_data_r [DEPTH];

    logic            in_fetch_s;
    logic            fifo_empty_s;
    logic            mem_req_int_s;
    logic [AW-1:0]   mem_addr_int_s;
    logic            completion_s;
    logic            stall_s;
    logic [AW-1:0]   head_addr_s;
    logic [DW-1:0]   head_data_s;
    logic            hit_s;
    logic            bypass_s;
    logic            pending_s;
    logic            miss_s;
    logic            clear_s;
    logic            push_s;
    logic            pop_s;

    // Request/hit decode shared by the FSM, the datapath and the outputs
    always_comb begin
        in_fetch_s     = (state_r == ST_FETCH);
        fifo_empty_s   = (count_r == {CW{1'b0}});
        // Once raised in FETCH the request stays up: count only grows on completion.
        mem_req_int_s  = (in_fetch_s && (count_r < CW'(DEPTH))) || (state_r == ST_DRAIN);
        mem_addr_int_s = (state_r == ST_DRAIN) ? drain_addr_r : fetch_addr_r;
        completion_s   = mem_req_int_s & mem_ready_i;
        // Outstanding read that will still be in flight after this edge
        stall_s        = mem_req_int_s & ~mem_ready_i;
        head_addr_s    = fifo_addr_r[rd_ptr_r];
        head_data_s    = fifo_data_r[rd_ptr_r];

        hit_s    = core_req_i & ~flush_i & in_fetch_s & ~fifo_empty_s
                   & (head_addr_s == core_addr_i);
        bypass_s = core_req_i & ~flush_i & in_fetch_s & fifo_empty_s & completion_s
                   & (mem_addr_int_s == core_addr_i);
        // Waiting only makes sense while streaming; in IDLE no read would ever come.
        if (mem_req_int_s) begin
            pending_s = core_req_i & in_fetch_s & fifo_empty_s & ~completion_s
                        & (mem_addr_int_s == core_addr_i);
        end else begin
            pending_s = core_req_i & in_fetch_s & fifo_empty_s
                        & (fetch_addr_r == core_addr_i);
        end
        miss_s  = core_req_i & ~hit_s & ~bypass_s & ~pending_s;
        clear_s = flush_i | miss_s;
        push_s  = in_fetch_s & completion_s & ~bypass_s & ~clear_s;
        pop_s   = hit_s & ~clear_s;
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; flush outranks a miss
    always_comb begin
        state_nxt_s = state_r;
        if (flush_i) begin
            state_nxt_s = stall_s ? ST_DRAIN : ST_IDLE;
        end else if (miss_s) begin
            state_nxt_s = stall_s ? ST_DRAIN : ST_FETCH;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_FETCH: state_nxt_s = ST_FETCH;
                ST_DRAIN: begin
                    if (completion_s) begin
                        state_nxt_s = redirect_r ? ST_FETCH : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs; reset masks everything in the cycle it is asserted
    always_comb begin
        if (rst_i) begin
            core_ready_o = 1'b0;
            core_data_o  = {DW{1'b0}};
            mem_req_o    = 1'b0;
            mem_addr_o   = {AW{1'b0}};
        end else begin
            core_ready_o = hit_s | bypass_s;
            if (hit_s) begin
                core_data_o = head_data_s;
            end else if (bypass_s) begin
                core_data_o = mem_data_i;
            end else begin
                core_data_o = {DW{1'b0}};
            end
            mem_req_o  = mem_req_int_s;
            mem_addr_o = mem_req_int_s ? mem_addr_int_s : {AW{1'b0}};
        end
    end

    // Fetch address, drain address and redirect flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_addr_r <= {AW{1'b0}};
            drain_addr_r <= {AW{1'b0}};
            redirect_r   <= 1'b0;
        end else if (flush_i) begin
            redirect_r <= 1'b0;
            if (stall_s) begin
                drain_addr_r <= mem_addr_int_s;
            end else begin
                drain_addr_r <= drain_addr_r;
            end
        end else if (miss_s) begin
            fetch_addr_r <= core_addr_i;
            redirect_r   <= stall_s;
            if (stall_s) begin
                drain_addr_r <= mem_addr_int_s;
            end else begin
                drain_addr_r <= drain_addr_r;
            end
        end else if (in_fetch_s && completion_s) begin
            // Wraps naturally modulo 2^AW
            fetch_addr_r <= fetch_addr_r + AW'(4);
        end else begin
            fetch_addr_r <= fetch_addr_r;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_s) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful below count_r, so no reset
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= mem_addr_int_s;
            fifo_data_r[wr_ptr_r] <= mem_data_i;
        end
    end

endmodule
